adder_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit signed adder datapath among N_REQ requesters. It accepts one operand pair per grant, runs it through the shared adder, and returns a registered sum tagged with the requester index, carry-out and signed overflow. It sits between requester blocks and the shared adder, replacing per-requester adder instances.

---
 rtl/adder_rr_arbiter_if.sv | 37 +++
 rtl/adder_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_rr_arbiter_if.sv
// rtl/adder_rr_arbiter_if.sv - request/result bundle for the shared-adder arbiter
// Signals:
//   req, a_bus, b_bus, cin_bus  - per-requester request and operands (master drives)
//   gnt                         - one-hot grant back to the requesters (slave drives)
//   res_valid/res_ready         - result handshake
//   res_id/res_sum/res_cout/res_ovf - result payload
//   busy, ops_done              - status
interface adder_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_bus;
  logic [N_REQ*WIDTH-1:0] b_bus;
  logic [N_REQ-1:0]       cin_bus;
  logic [N_REQ-1:0]       gnt;
  logic                   res_valid;
  logic                   res_ready;
  logic [IDW-1:0]         res_id;
  logic [WIDTH-1:0]       res_sum;
  logic                   res_cout;
  logic                   res_ovf;
  logic                   busy;
  logic [CNTW-1:0]        ops_done;

  modport master (
    output req, a_bus, b_bus, cin_bus, res_ready,
    input  gnt, res_valid, res_id, res_sum, res_cout, res_ovf, busy, ops_done
  );

  modport slave (
    input  req, a_bus, b_bus, cin_bus, res_ready,
    output gnt, res_valid, res_id, res_sum, res_cout, res_ovf, busy, ops_done
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin sequencer sharing one signed adder among requesters
// Ports:
//   clk - clock, all state updates on rising edge
//   rst - asynchronous active-high reset
//   bus - adder_rr_arbiter_if.slave: requests/operands in, one-hot gnt out,
//         registered result with valid/ready handshake, busy and ops_done status
module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  adder_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [CNTW-1:0]  ops_q, ops_d;

  // Round-robin pick: scan ptr+1, ptr+2, ... wrapping; first requester found wins.
  logic             win_found;
  logic [IDW-1:0]   win_id;
  int               cand;
  logic [IDW-1:0]   cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_id    = cand_idx;
      end
    end
  end

  // Shared adder on the latched operands; one extra bit carries the unsigned carry out.
  logic [WIDTH:0] add_full;
  logic           add_ovf;

  assign add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign add_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);

  // Grant is combinational and only offered in IDLE; held off while reset is asserted
  // so every output shows its reset value immediately.
  always_comb begin
    bus.gnt = '0;
    if (state_q == IDLE && win_found && !rst) bus.gnt[win_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    id_d     = id_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    res_id_d = res_id_q;
    ops_d    = ops_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d   = win_id;
          a_d     = bus.a_bus[win_id*WIDTH +: WIDTH];
          b_d     = bus.b_bus[win_id*WIDTH +: WIDTH];
          cin_d   = bus.cin_bus[win_id];
          id_d    = win_id;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d    = add_full[WIDTH-1:0];
        cout_d   = add_full[WIDTH];
        ovf_d    = add_ovf;
        res_id_d = id_q;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.res_ready) begin
          ops_d   = ops_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDW'(N_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_id_q <= '0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      res_id_q <= res_id_d;
      ops_q    <= ops_d;
    end
  end

  assign bus.res_valid = (state_q == OUT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - self-checking bench for adder_rr_arbiter
module tb_adder_rr_arbiter;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst4 = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_rr_arbiter_if #(.N_REQ(4), .WIDTH(32), .IDW(2), .CNTW(16)) bus ();
  adder_rr_arbiter_if #(.N_REQ(4), .WIDTH(32), .IDW(2), .CNTW(4))  bus4 ();

  adder_rr_arbiter #(.N_REQ(4), .WIDTH(32), .IDW(2), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adder_rr_arbiter #(.N_REQ(4), .WIDTH(32), .IDW(2), .CNTW(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT event", name);
  endtask

  // Reference arithmetic from integer ranges rather than bit tricks.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint s;
    s = longint'(a) + longint'(b) + longint'(c);
    return s[31:0];
  endfunction

  function automatic logic ref_cout(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint s;
    s = longint'(a) + longint'(b) + longint'(c);
    return s >= 64'sd4294967296;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (((r >> i) & 4'b0001) != 4'b0000) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_id(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (((g >> i) & 4'b0001) != 4'b0000) return i;
    return -1;
  endfunction

  // Model: 0 = waiting for a grant, 1 = operands taken, 2 = result presented.
  int          m_phase, m_last, m_ops, m_id, p_id, pk;
  logic [31:0] p_a, p_b, m_sum;
  logic        p_cin, m_cout, m_ovf;
  logic [3:0]  exp_gnt;

  always_comb pk = rr_pick(bus.req, m_last);
  always_comb exp_gnt = (m_phase == 0 && !rst && pk >= 0) ? (4'b0001 << pk) : 4'b0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_last <= 3; m_ops <= 0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_id <= 0;
    end else begin
      case (m_phase)
        0: if (pk >= 0) begin
          p_a <= bus.a_bus[pk*32 +: 32];
          p_b <= bus.b_bus[pk*32 +: 32];
          p_cin <= bus.cin_bus[pk];
          p_id <= pk;
          m_last <= pk;
          m_phase <= 1;
        end
        1: begin
          m_sum <= ref_sum(p_a, p_b, p_cin);
          m_cout <= ref_cout(p_a, p_b, p_cin);
          m_ovf <= ref_ovf(p_a, p_b, p_cin);
          m_id <= p_id;
          m_phase <= 2;
        end
        default: if (bus.res_ready) begin
          m_ops <= (m_ops + 1) % 65536;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_gnt", bus.gnt, exp_gnt);
      check("cmp_busy", bus.busy, m_phase != 0);
      check("cmp_valid", bus.res_valid, m_phase == 2);
      check("cmp_ops_done", bus.ops_done, m_ops);
      check("cmp_sum", bus.res_sum, m_sum);
      check("cmp_id", bus.res_id, m_id);
      check("cmp_cout", bus.res_cout, m_cout);
      check("cmp_ovf", bus.res_ovf, m_ovf);
    end
  end

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.a_bus[id*32 +: 32] = a;
    bus.b_bus[id*32 +: 32] = b;
    bus.cin_bus = (bus.cin_bus & ~(4'b0001 << id)) | ({3'b000, c} << id);
  endtask

  task automatic wait_gnt(input logic [3:0] g, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.gnt !== g && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (bus.gnt !== g) tmo(name);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (bus.res_valid !== 1'b1) tmo(name);
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] es, input logic ec, input logic eo, input string tag);
    int t0;
    @(posedge clk); #1;
    set_op(id, a, b, c);
    bus.req = bus.req | (4'b0001 << id);
    wait_gnt(4'b0001 << id, {tag, "_gnt"});
    t0 = cyc;
    @(posedge clk); #1;
    bus.req = bus.req & ~(4'b0001 << id);
    wait_valid({tag, "_valid"});
    check({tag, "_latency"}, cyc - t0, 2);
    check({tag, "_sum"}, bus.res_sum, es);
    check({tag, "_cout"}, bus.res_cout, ec);
    check({tag, "_ovf"}, bus.res_ovf, eo);
    check({tag, "_id"}, bus.res_id, id);
  endtask

  int g_ids[6];
  int g_cyc[6];
  int r_ids[6];
  int gi, ri, n, nv, ops_snap;

  initial begin
    bus.req = '0; bus.a_bus = '0; bus.b_bus = '0; bus.cin_bus = '0; bus.res_ready = 1'b1;
    bus4.req = '0; bus4.a_bus = '0; bus4.b_bus = '0; bus4.cin_bus = '0; bus4.res_ready = 1'b1;

    @(posedge clk); cmp_en = 1'b1;
    @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ops", bus.ops_done, 0);
    check("rst_sum", bus.res_sum, 0);
    check("rst_id", bus.res_id, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Back-to-back single requester.
    do_op(0, 32'd36865, 32'd33023, 1'b0, 32'd69888, 1'b0, 1'b0, "op1");
    do_op(0, 32'd9943121, -32'sd3302367, 1'b0, 32'd6640754, 1'b1, 1'b0, "op2");
    do_op(0, -32'sd3686, 32'd3023, 1'b0, -32'sd663, 1'b0, 1'b0, "op3");
    @(posedge clk); #1;
    @(negedge clk);
    check("ops_done_3", bus.ops_done, 3);

    // Flag corners.
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos");
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "cin_wrap");
    do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "ovf_neg");

    // Fairness with all four requesting from reset.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, i * 100 + 1, i, 1'b0);
    bus.req = 4'hF;
    @(posedge clk); #1; rst = 1'b0;
    n = 0; gi = 0; ri = 0;
    while ((gi < 6 || ri < 6) && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.gnt != 4'b0000 && gi < 6) begin
        g_ids[gi] = onehot_id(bus.gnt);
        g_cyc[gi] = cyc;
        gi++;
      end
      if (bus.res_valid && ri < 6) begin
        r_ids[ri] = int'(bus.res_id);
        ri++;
      end
    end
    if (gi < 6 || ri < 6) tmo("fair_collect");
    for (int i = 0; i < gi; i++) check("fair_gnt_order", g_ids[i], i % 4);
    for (int i = 1; i < gi; i++) check("fair_gnt_spacing", g_cyc[i] - g_cyc[i-1], 3);
    for (int i = 0; i < ri; i++) check("fair_res_id", r_ids[i], i % 4);
    @(posedge clk); #1; bus.req = 4'b0000;

    // Backpressure with another requester pending.
    repeat (4) @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    set_op(2, 32'd1000, 32'd2345, 1'b0);
    bus.req = 4'b0100;
    wait_gnt(4'b0100, "bp_gnt");
    @(posedge clk); #1;
    set_op(3, 32'd7, 32'd8, 1'b1);
    bus.req = 4'b1000;
    wait_valid("bp_valid");
    ops_snap = m_ops;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", bus.res_valid, 1);
      check("bp_sum_hold", bus.res_sum, 32'd3345);
      check("bp_no_gnt", bus.gnt, 0);
      check("bp_ops_hold", bus.ops_done, ops_snap);
      @(negedge clk);
    end
    @(posedge clk); #1; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ops_after", bus.ops_done, ops_snap + 1);
    check("bp_next_gnt", bus.gnt, 4'b1000);
    @(posedge clk); #1; bus.req = 4'b0000;
    wait_valid("bp2_valid");
    check("bp2_sum", bus.res_sum, 32'd16);
    check("bp2_id", bus.res_id, 3);

    // Reset while the adder stage holds an operation.
    repeat (3) @(posedge clk);
    #1;
    set_op(0, 32'd1, 32'd2, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(4'b0001, "rm_gnt0");
    @(posedge clk); #1;
    check("rm_busy_add", bus.busy, 1);
    rst = 1'b1;
    set_op(1, 32'd50, 32'd60, 1'b0);
    set_op(3, 32'd9, 32'd9, 1'b0);
    bus.req = 4'b1010;
    #1;
    check("rm_gnt", bus.gnt, 0);
    check("rm_busy", bus.busy, 0);
    check("rm_valid", bus.res_valid, 0);
    check("rm_sum", bus.res_sum, 0);
    check("rm_id", bus.res_id, 0);
    check("rm_cout", bus.res_cout, 0);
    check("rm_ovf", bus.res_ovf, 0);
    check("rm_ops", bus.ops_done, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rm_first_gnt", bus.gnt, 4'b0010);
    @(posedge clk); #1; bus.req = 4'b0000;
    wait_valid("rm_res_valid");
    check("rm_res_id", bus.res_id, 1);
    check("rm_res_sum", bus.res_sum, 32'd110);

    // Counter wrap on the narrow-counter instance.
    @(posedge clk); #1;
    bus4.a_bus[31:0] = 32'd5;
    bus4.b_bus[31:0] = 32'd6;
    bus4.req = 4'b0001;
    rst4 = 1'b0;
    nv = 0; n = 0;
    while (nv < 17 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus4.res_valid) nv++;
    end
    if (nv < 17) tmo("wrap_ops_count");
    check("wrap_sum", bus4.res_sum, 32'd11);
    @(posedge clk); #1; bus4.req = 4'b0000;
    @(negedge clk);
    check("wrap_ops_done", bus4.ops_done, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
